ss_division_ctrl: RTL and testbench

//  Sequencer for one 3-bit stochastic-symbol division evaluation. Accepts an (x,y) operand pair over a

---
 rtl/ss_div_pkg.sv | 25 ++
 rtl/ss_lfsr_8bit.sv | 26 ++
 rtl/ss_division_ctrl.sv | 154 +++++++++++++++
 tb/tb_ss_division_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_div_pkg.sv
// ss_div_pkg: shared widths, FSM state encodings and the LFSR step function
// for the stochastic-symbol division controller.
package ss_div_pkg;

  localparam int SS_W   = 3;
  localparam int OPND_W = 10;
  localparam int RAND_W = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of the state).
  localparam logic [RAND_W-1:0] LFSR_TAPS = 8'hB8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FLUSH = 3'd1;
  localparam state_t ST_WARM  = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // One Fibonacci step: shift left, parity of tapped bits enters bit 0.
  function automatic logic [RAND_W-1:0] lfsr_advance(input logic [RAND_W-1:0] s);
    return {s[RAND_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ss_lfsr_8bit.sv
// ss_lfsr_8bit: 8-bit Fibonacci LFSR with seed load and step enable.
// Reset and load both restart the sequence from the seed, so a nonzero
// seed keeps the state nonzero forever.
module ss_lfsr_8bit
  import ss_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RAND_W-1:0] seed,
  input  logic              step,
  output logic [RAND_W-1:0] q
);

  // Seed on reset/load, otherwise advance one step when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_advance(q);
    end
  end

endmodule

// File: rtl/ss_division_ctrl.sv
// ss_division_ctrl: sequences one stochastic-symbol division evaluation.
// Accepts an (x,y) request, flushes the datapath, warms it up, accumulates
// dp_z_ss over WINDOW cycles and hands back the sum on a valid/ready channel.
// Optional feature macro: SS_DIV_ABORT_EN adds an 'abort' input that drops
// an in-flight evaluation (FLUSH/WARM/RUN) back to IDLE without a result.
module ss_division_ctrl
  import ss_div_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int WARMUP = 8,
  parameter int ACC_W  = 11,
  parameter logic [RAND_W-1:0] SEED_X = 8'hA5,
  parameter logic [RAND_W-1:0] SEED_Y = 8'h3C,
  parameter logic [RAND_W-1:0] SEED_Z = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SS_DIV_ABORT_EN
  input  logic              abort,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPND_W-1:0] req_x,
  input  logic [OPND_W-1:0] req_y,
  output logic [OPND_W-1:0] dp_x,
  output logic [OPND_W-1:0] dp_y,
  output logic [RAND_W-1:0] dp_x_rand,
  output logic [RAND_W-1:0] dp_y_rand,
  output logic [RAND_W-1:0] dp_z_rand,
  output logic              dp_rst,
  input  logic [SS_W-1:0]   dp_z_ss,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_count,
  output logic              busy
);

  localparam int CNT_MAX = (WINDOW > WARMUP) ? WINDOW : WARMUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // WARM_LAST is never compared when WARMUP is 0 because WARM is skipped.
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(WINDOW - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic               in_flight;
  logic               lfsr_load;
  logic               lfsr_step;
  logic               abort_hit;

  assign in_flight = (state == ST_FLUSH) || (state == ST_WARM) || (state == ST_RUN);

`ifdef SS_DIV_ABORT_EN
  assign abort_hit = abort && in_flight;
`else
  assign abort_hit = 1'b0;
`endif

  assign lfsr_load = (state == ST_FLUSH);
  assign lfsr_step = (state == ST_WARM) || (state == ST_RUN);

  assign req_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign res_count = acc;
  // The datapath uses an active-low reset: hold it while we reset or flush.
  assign dp_rst    = ~(rst || (state == ST_FLUSH));

  // Next-state decode; an abort overrides every in-flight transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req_valid) state_next = ST_FLUSH;
      ST_FLUSH: state_next = (WARMUP > 0) ? ST_WARM : ST_RUN;
      ST_WARM:  if (cnt == WARM_LAST) state_next = ST_RUN;
      ST_RUN:   if (cnt == RUN_LAST) state_next = ST_DONE;
      ST_DONE:  if (res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort_hit) state_next = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Phase cycle counter: restarts on every state change, counts in WARM/RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (lfsr_step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Symbol accumulator: cleared on flush/abort, sums only RUN-cycle symbols.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if ((state == ST_FLUSH) || abort_hit) begin
      acc <= '0;
    end else if (state == ST_RUN) begin
      acc <= acc + {{(ACC_W-SS_W){1'b0}}, dp_z_ss};
    end
  end

  // Operand capture on the request handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_x <= '0;
      dp_y <= '0;
    end else if ((state == ST_IDLE) && req_valid) begin
      dp_x <= req_x;
      dp_y <= req_y;
    end
  end

  ss_lfsr_8bit u_lfsr_x (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_X),
    .step (lfsr_step),
    .q    (dp_x_rand)
  );

  ss_lfsr_8bit u_lfsr_y (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_Y),
    .step (lfsr_step),
    .q    (dp_y_rand)
  );

  ss_lfsr_8bit u_lfsr_z (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_Z),
    .step (lfsr_step),
    .q    (dp_z_rand)
  );

endmodule

// File: tb/tb_ss_division_ctrl.sv
// tb_ss_division_ctrl: scoreboard bench for ss_division_ctrl with a stub
// divider driving dp_z_ss (constant, phase-dependent or LFSR-derived symbols).
module tb_ss_division_ctrl;

  localparam int WINDOW    = 256;
  localparam int WARMUP    = 8;
  localparam int ACC_W     = 11;
  localparam int RUN_START = 2 + WARMUP;
  localparam int LATENCY   = 2 + WARMUP + WINDOW;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [9:0]       req_x;
  logic [9:0]       req_y;
  logic [9:0]       dp_x;
  logic [9:0]       dp_y;
  logic [7:0]       dp_x_rand;
  logic [7:0]       dp_y_rand;
  logic [7:0]       dp_z_rand;
  logic             dp_rst;
  logic [2:0]       dp_z_ss;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_count;
  logic             busy;
`ifdef SS_DIV_ABORT_EN
  logic             abort;
`endif

  int assert_count = 0;
  int fail_count   = 0;
  int since_acc    = 0;
  int stub_mode    = 0;
  logic [2:0] warm_val = 3'd0;
  logic [2:0] run_val  = 3'd0;
  logic [ACC_W-1:0] scoreboard[$];

  ss_division_ctrl #(
    .WINDOW (WINDOW),
    .WARMUP (WARMUP),
    .ACC_W  (ACC_W),
    .SEED_X (8'hA5),
    .SEED_Y (8'h3C),
    .SEED_Z (8'h5A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SS_DIV_ABORT_EN
    .abort     (abort),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_x_rand (dp_x_rand),
    .dp_y_rand (dp_y_rand),
    .dp_z_rand (dp_z_rand),
    .dp_rst    (dp_rst),
    .dp_z_ss   (dp_z_ss),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bench reference LFSR: x^8+x^6+x^5+x^4+1, shift left.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Stub divider symbol for the LFSR-driven mode.
  function automatic logic [2:0] mix(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [9:0] x);
    return a[2:0] ^ b[4:2] ^ c[7:5] ^ x[2:0];
  endfunction

  // Reference model of the expected result for one evaluation.
  function automatic logic [ACC_W-1:0] model_sum(input int mode, input logic [2:0] rv,
                                                 input logic [9:0] x);
    logic [7:0] lx;
    logic [7:0] ly;
    logic [7:0] lz;
    int sum;
    lx = 8'hA5;
    ly = 8'h3C;
    lz = 8'h5A;
    sum = 0;
    if (mode != 2) return ACC_W'(int'(rv) * WINDOW);
    for (int i = 0; i < WARMUP; i++) begin
      lx = ref_step(lx);
      ly = ref_step(ly);
      lz = ref_step(lz);
    end
    for (int k = 0; k < WINDOW; k++) begin
      sum += int'(mix(lx, ly, lz, x));
      lx = ref_step(lx);
      ly = ref_step(ly);
      lz = ref_step(lz);
    end
    return ACC_W'(sum);
  endfunction

  // Cycles since the last accepted request (1 during the FLUSH cycle).
  always @(posedge clk) begin
    if (req_valid && req_ready && !rst) since_acc <= 1;
    else since_acc <= since_acc + 1;
  end

  // Stub divider output.
  always_comb begin
    dp_z_ss = 3'd0;
    if (stub_mode == 2) dp_z_ss = mix(dp_x_rand, dp_y_rand, dp_z_rand, dp_x);
    else if (since_acc >= RUN_START) dp_z_ss = run_val;
    else dp_z_ss = warm_val;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request and check the flush cycle; expected sum goes to the scoreboard.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input int mode,
                               input logic [2:0] wv, input logic [2:0] rv);
    @(negedge clk);
    stub_mode = mode;
    warm_val  = wv;
    run_val   = rv;
    checkOutput("req_ready_idle", req_ready, 1);
    req_x     = x;
    req_y     = y;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    scoreboard.push_back(model_sum(mode, rv, x));
    checkOutput("flush_dp_rst", dp_rst, 0);
    checkOutput("flush_busy", busy, 1);
    checkOutput("capture_x", dp_x, x);
    checkOutput("capture_y", dp_y, y);
  endtask

  // Wait for the result, check latency/count, optionally stall, then accept it.
  task automatic waitResult(input string tag, input logic [9:0] x, input int hold,
                            input logic early_ready);
    int rst_glitch;
    int zero_rand;
    int unstable;
    logic [ACC_W-1:0] exp;
    rst_glitch = 0;
    zero_rand  = 0;
    unstable   = 0;
    while (!res_valid && since_acc < LATENCY + 50) begin
      res_ready = early_ready && (since_acc < 200);
      @(negedge clk);
      if (!dp_rst) rst_glitch++;
      if (dp_x_rand == 8'd0 || dp_y_rand == 8'd0 || dp_z_rand == 8'd0) zero_rand++;
    end
    res_ready = 1'b0;
    checkOutput({tag, "_latency"}, since_acc, LATENCY);
    checkOutput({tag, "_dp_rst_glitch"}, rst_glitch, 0);
    checkOutput({tag, "_lfsr_zero"}, zero_rand, 0);
    checkOutput({tag, "_sb_size"}, scoreboard.size(), 1);
    exp = (scoreboard.size() > 0) ? scoreboard.pop_front() : '0;
    checkOutput({tag, "_count"}, res_count, exp);
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0];
      req_x     = 10'h155;
      req_y     = 10'h2AA;
      @(negedge clk);
      if (!res_valid || res_count !== exp || req_ready) unstable++;
    end
    req_valid = 1'b0;
    checkOutput({tag, "_done_stable"}, unstable, 0);
    checkOutput({tag, "_dp_x_held"}, dp_x, x);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, req_ready, 1);
    checkOutput({tag, "_idle_valid"}, res_valid, 0);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    res_ready = 1'b0;
`ifdef SS_DIV_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_dp_rst_low", dp_rst, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_res_count", res_count, 0);
    checkOutput("reset_dp_x", dp_x, 0);
    checkOutput("reset_x_rand", dp_x_rand, 8'hA5);
    checkOutput("reset_y_rand", dp_y_rand, 8'h3C);
    checkOutput("reset_z_rand", dp_z_rand, 8'h5A);

    // Constant 7 symbols: full-scale sum.
    applyStimulus(10'd512, 10'd1023, 0, 3'd7, 3'd7);
    waitResult("const7", 10'd512, 0, 1'b0);

    // Warm-up symbols excluded; res_ready before DONE ignored.
    applyStimulus(10'd5, 10'd9, 1, 3'd0, 3'd1);
    waitResult("warm0_run1", 10'd5, 0, 1'b1);
    applyStimulus(10'd6, 10'd11, 1, 3'd5, 3'd1);
    waitResult("warm5_run1", 10'd6, 0, 1'b0);

    // Stalled result with request pulses in DONE.
    applyStimulus(10'd100, 10'd200, 0, 3'd3, 3'd3);
    waitResult("stall", 10'd100, 20, 1'b0);

    // Reset mid-evaluation.
    applyStimulus(10'd300, 10'd600, 0, 3'd7, 3'd7);
    while (since_acc < 100) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_dp_rst", dp_rst, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_req_ready", req_ready, 1);
    checkOutput("midrst_res_valid", res_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_dp_x", dp_x, 0);
    checkOutput("midrst_res_count", res_count, 0);
    checkOutput("midrst_x_rand", dp_x_rand, 8'hA5);
    scoreboard.delete();
    applyStimulus(10'd77, 10'd33, 2, 3'd0, 3'd0);
    waitResult("after_rst", 10'd77, 0, 1'b0);

    // Back-to-back identical LFSR-driven evaluations.
    applyStimulus(10'd512, 10'd1023, 2, 3'd0, 3'd0);
    waitResult("lfsr_a", 10'd512, 0, 1'b0);
    applyStimulus(10'd512, 10'd1023, 2, 3'd0, 3'd0);
    waitResult("lfsr_b", 10'd512, 0, 1'b0);

`ifdef SS_DIV_ABORT_EN
    // Abort mid-run: back to IDLE next cycle, no result ever raised.
    begin
      int seen_valid;
      seen_valid = 0;
      applyStimulus(10'd400, 10'd500, 0, 3'd7, 3'd7);
      while (since_acc < 50) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_req_ready", req_ready, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_res_count", res_count, 0);
      repeat (LATENCY) begin
        @(negedge clk);
        if (res_valid) seen_valid++;
      end
      checkOutput("abort_no_valid", seen_valid, 0);
      scoreboard.delete();
      applyStimulus(10'd1, 10'd2, 0, 3'd2, 3'd2);
      waitResult("post_abort", 10'd1, 0, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
